fluxo_dados_genius: RTL and testbench
=====================================

FLUXO_DADOS_GENIUS -- requirements
Module: fluxo_dados_genius

Interface
REQ-001 Parameter WIDTH, default 4: width of chaves, stored jogada and memory word; SHALL be >=2.
REQ-002 Parameter ADDR_BITS, default 4: address width; memory depth SHALL be 2**ADDR_BITS.
REQ-003 Parameter TIMEOUT_CYCLES, default 5000: number of counted cycles before timeout; SHALL be >=2.
REQ-004 Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- chaves  in  WIDTH  player input.
- zeraC, contaC  in  1  address counter: clear, count.
- zeraL, contaL  in  1  limit (round) counter: clear, count.
- zeraR, registraR  in  1  jogada register: clear, load.
- gravaM  in  1  memory write enable.
- zeraT, contaT  in  1  timeout counter: clear, count.
- igual  out  1  memory word equals stored jogada.
- enderecoIgualLimite  out  1  address equals limit.
- fimC, fimL  out  1  address / limit at all-ones.
- jogada_feita  out  1  one-cycle pulse on new play.
- timeout  out  1  timeout reached.
- db_tem_jogada  out  1  OR of chaves.
- db_contagem, db_limite  out  ADDR_BITS  counter values.
- db_jogada, db_memoria  out  WIDTH  register output, memory read data.

Function
REQ-005 Address counter: per edge, zeraC -> 0; else contaC -> +1 modulo 2**ADDR_BITS (all-ones wraps to 0); else hold.
REQ-006 Limit counter: same rules as REQ-005 using zeraL/contaL.
REQ-007 fimC = (address == all-ones), fimL = (limit == all-ones), enderecoIgualLimite = (address == limit); all combinational.
REQ-008 Jogada register: zeraR -> 0; else registraR -> chaves; else hold; zeraR wins over registraR.
REQ-009 Memory: synchronous RAM, 2**ADDR_BITS x WIDTH; read registered, db_memoria reflects address one edge after that address appears.
REQ-010 gravaM=1 at an edge writes the jogada register value (pre-edge) to the pre-edge address.
REQ-011 Read-during-write to same address returns old data (read-first); new data visible on the following read.
REQ-012 Initial memory contents: word i = one-hot 1<<(i mod WIDTH); reset SHALL NOT alter memory contents.
REQ-013 igual = (db_memoria == db_jogada), combinational, full WIDTH compare.
REQ-014 db_tem_jogada = OR of chaves, combinational.
REQ-015 Edge detector: internal bit prev <= db_tem_jogada every edge; jogada_feita = db_tem_jogada AND NOT prev; holding keys yields exactly one pulse.
REQ-016 Simultaneous contaC with gravaM: write uses pre-increment address.

Reset
REQ-017 reset=1 at an edge: address, limit, jogada register, prev, timeout count, memory read register all -> 0; reset has priority over every zera/conta/registra/grava input (no memory write occurs).
REQ-018 Outputs after reset: db_contagem=0, db_limite=0, db_jogada=0, db_memoria=0, enderecoIgualLimite=1, fimC=0, fimL=0, timeout=0, igual=1.
REQ-019 Reset mid-operation discards pending count/write; next edge after reset release resumes from zeroed state.

Configuration
REQ-020 Macro FLUXO_DADOS_TIMEOUT_EN defined: timeout counter of width ceil(log2(TIMEOUT_CYCLES)); zeraT -> 0, else contaT -> +1 saturating at TIMEOUT_CYCLES-1; timeout = (count == TIMEOUT_CYCLES-1), stays high until zeraT or reset.
REQ-021 Macro undefined: no timeout counter synthesised, timeout tied 0, zeraT/contaT ignored.

Verification (WIDTH=4, ADDR_BITS=4, TIMEOUT_CYCLES=8)
REQ-022 Reset, then contaC 15 edges -> db_contagem=15, fimC=1; one more -> db_contagem=0, fimC=0.
REQ-023 After reset, wait 1 edge: db_memoria=0001; chaves=0001, registraR 1 edge -> igual=1; chaves=0100 registered -> igual=0.
REQ-024 Register 1000, gravaM at address 3 -> same-cycle read still 1000's predecessor 1000? no: old word 1000 (3 mod 4 -> 1000); then register 0010, gravaM at address 3, next edge db_memoria=0010.
REQ-025 chaves 0000->0010 held 5 cycles -> jogada_feita high exactly 1 cycle; return to 0000, then 0001 -> second single pulse.
REQ-026 contaL 2 edges, contaC 2 edges -> enderecoIgualLimite=1; contaC 1 more -> 0; zeraC with contaC same edge -> db_contagem=0.
REQ-027 FLUXO_DADOS_TIMEOUT_EN defined: contaT 7 edges -> timeout=1, stays 1 with further contaT; zeraT -> timeout=0; undefined build -> timeout=0 throughout.

Source files
------------

// File: rtl/fluxo_dados_genius.sv
// Datapath for a Genius/Simon-style memory game: address and round counters, play register,
// sequence RAM, play edge detector and an optional timeout counter (macro FLUXO_DADOS_TIMEOUT_EN).
module fluxo_dados_genius #(
  parameter int WIDTH          = 4,
  parameter int ADDR_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     chaves,
  input  logic                 zeraC,
  input  logic                 contaC,
  input  logic                 zeraL,
  input  logic                 contaL,
  input  logic                 zeraR,
  input  logic                 registraR,
  input  logic                 gravaM,
  input  logic                 zeraT,
  input  logic                 contaT,
  output logic                 igual,
  output logic                 enderecoIgualLimite,
  output logic                 fimC,
  output logic                 fimL,
  output logic                 jogada_feita,
  output logic                 timeout,
  output logic                 db_tem_jogada,
  output logic [ADDR_BITS-1:0] db_contagem,
  output logic [ADDR_BITS-1:0] db_limite,
  output logic [WIDTH-1:0]     db_jogada,
  output logic [WIDTH-1:0]     db_memoria
);

  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;
  localparam logic [WIDTH-1:0]     ONE_HOT_0 = WIDTH'(1);

  logic [ADDR_BITS-1:0] r_addr;
  logic [ADDR_BITS-1:0] r_lim;
  logic [WIDTH-1:0]     r_jogada;
  logic [WIDTH-1:0]     r_rdata;
  logic                 r_prev;
  logic [WIDTH-1:0]     r_mem [DEPTH];
  // Tracks which words have ever been written; unwritten words read back their one-hot default.
  // Only power-up initialised, so reset leaves the stored sequence intact.
  logic [DEPTH-1:0]     r_wr = '0;

  logic                 w_tem_jogada;
  logic [WIDTH-1:0]     w_rd_word;

  function automatic logic [WIDTH-1:0] f_default_word(input logic [ADDR_BITS-1:0] a);
    return ONE_HOT_0 << (int'(a) % WIDTH);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr <= '0;
    end else if (zeraC) begin
      r_addr <= '0;
    end else if (contaC) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lim <= '0;
    end else if (zeraL) begin
      r_lim <= '0;
    end else if (contaL) begin
      r_lim <= r_lim + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_jogada <= '0;
    end else if (zeraR) begin
      r_jogada <= '0;
    end else if (registraR) begin
      r_jogada <= chaves;
    end
  end

  assign w_rd_word = r_wr[r_addr] ? r_mem[r_addr] : f_default_word(r_addr);

  // Read-first RAM: the read register samples the old word on the same edge as a write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd_word;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && gravaM) begin
      r_mem[r_addr] <= r_jogada;
      r_wr[r_addr]  <= 1'b1;
    end
  end

  assign w_tem_jogada = |chaves;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= w_tem_jogada;
    end
  end

`ifdef FLUXO_DADOS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_tcount;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tcount <= '0;
    end else if (zeraT) begin
      r_tcount <= '0;
    end else if (contaT && (r_tcount != T_LAST)) begin
      r_tcount <= r_tcount + 1'b1;
    end
  end

  assign timeout = (r_tcount == T_LAST);
`else
  logic w_unused_t;
  assign w_unused_t = zeraT ^ contaT;
  assign timeout    = 1'b0;
`endif

  assign db_contagem         = r_addr;
  assign db_limite           = r_lim;
  assign db_jogada           = r_jogada;
  assign db_memoria          = r_rdata;
  assign db_tem_jogada       = w_tem_jogada;
  assign jogada_feita        = w_tem_jogada & ~r_prev;
  assign igual               = (r_rdata == r_jogada);
  assign enderecoIgualLimite = (r_addr == r_lim);
  assign fimC                = (r_addr == ADDR_LAST);
  assign fimL                = (r_lim == ADDR_LAST);

endmodule

// File: tb/tb_fluxo_dados_genius.sv
// Self-checking bench for fluxo_dados_genius: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model of the game datapath.
module tb_fluxo_dados_genius;

  localparam int W     = 4;
  localparam int AB    = 4;
  localparam int TO    = 8;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] chaves = '0;
  logic zeraC = 0, contaC = 0, zeraL = 0, contaL = 0, zeraR = 0, registraR = 0;
  logic gravaM = 0, zeraT = 0, contaT = 0;
  logic igual, enderecoIgualLimite, fimC, fimL, jogada_feita, timeout, db_tem_jogada;
  logic [AB-1:0] db_contagem, db_limite;
  logic [W-1:0]  db_jogada, db_memoria;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int m_addr, m_lim, m_jog, m_rd, m_t;
  bit m_prev;
  bit m_valid = 0;
  int m_mem[DEPTH];

  fluxo_dados_genius #(.WIDTH(W), .ADDR_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .chaves(chaves),
    .zeraC(zeraC), .contaC(contaC), .zeraL(zeraL), .contaL(contaL),
    .zeraR(zeraR), .registraR(registraR), .gravaM(gravaM),
    .zeraT(zeraT), .contaT(contaT),
    .igual(igual), .enderecoIgualLimite(enderecoIgualLimite),
    .fimC(fimC), .fimL(fimL), .jogada_feita(jogada_feita), .timeout(timeout),
    .db_tem_jogada(db_tem_jogada), .db_contagem(db_contagem), .db_limite(db_limite),
    .db_jogada(db_jogada), .db_memoria(db_memoria)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int a;
    if (reset) begin
      m_addr = 0; m_lim = 0; m_jog = 0; m_rd = 0; m_t = 0; m_prev = 0; m_valid = 1;
    end else begin
      a      = m_addr;
      m_rd   = m_mem[a];
      if (gravaM) m_mem[a] = m_jog;
      m_prev = (chaves != 0);
      if (zeraC) m_addr = 0; else if (contaC) m_addr = (m_addr + 1) % DEPTH;
      if (zeraL) m_lim = 0;  else if (contaL) m_lim = (m_lim + 1) % DEPTH;
      if (zeraR) m_jog = 0;  else if (registraR) m_jog = int'(chaves);
      if (zeraT) m_t = 0;    else if (contaT && m_t < TO - 1) m_t = m_t + 1;
    end
  endtask

  task automatic model_compare();
    chk("m.db_contagem", 32'(db_contagem), m_addr);
    chk("m.db_limite", 32'(db_limite), m_lim);
    chk("m.db_jogada", 32'(db_jogada), m_jog);
    chk("m.db_memoria", 32'(db_memoria), m_rd);
    chk("m.igual", 32'(igual), 32'(m_rd == m_jog));
    chk("m.eq_limite", 32'(enderecoIgualLimite), 32'(m_addr == m_lim));
    chk("m.fimC", 32'(fimC), 32'(m_addr == DEPTH - 1));
    chk("m.fimL", 32'(fimL), 32'(m_lim == DEPTH - 1));
    chk("m.tem_jogada", 32'(db_tem_jogada), 32'(chaves != 0));
    chk("m.jogada_feita", 32'(jogada_feita), 32'((chaves != 0) && !m_prev));
`ifdef FLUXO_DADOS_TIMEOUT_EN
    chk("m.timeout", 32'(timeout), 32'(m_t == TO - 1));
`else
    chk("m.timeout", 32'(timeout), 0);
`endif
  endtask

  // Inputs are set before calling; compare mid-cycle, then advance one rising edge.
  task automatic step();
    @(negedge clock);
    if (m_valid) model_compare();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    zeraC = 0; contaC = 0; zeraL = 0; contaL = 0; zeraR = 0; registraR = 0;
    gravaM = 0; zeraT = 0; contaT = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    step();
    reset = 0;
  endtask

  typedef struct {
    bit zc, cc, zl, cl;
    int e_cont, e_lim;
    bit e_eq;
  } vec_t;

  vec_t tbl[9];
  int pulses;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 1 << (i % W);

    tbl[0] = '{0, 0, 0, 1, 0, 1, 0};
    tbl[1] = '{0, 0, 0, 1, 0, 2, 0};
    tbl[2] = '{0, 1, 0, 0, 1, 2, 0};
    tbl[3] = '{0, 1, 0, 0, 2, 2, 1};
    tbl[4] = '{0, 1, 0, 0, 3, 2, 0};
    tbl[5] = '{1, 1, 0, 0, 0, 2, 0};
    tbl[6] = '{0, 0, 1, 1, 0, 0, 1};
    tbl[7] = '{0, 1, 0, 1, 1, 1, 1};
    tbl[8] = '{0, 0, 1, 0, 1, 0, 0};

    // reset with every other control asserted: reset must win
    chaves = 4'b1111; contaC = 1; contaL = 1; registraR = 1; gravaM = 1; contaT = 1;
    reset = 1;
    step();
    chk("rst.db_contagem", 32'(db_contagem), 0);
    chk("rst.db_limite", 32'(db_limite), 0);
    chk("rst.db_jogada", 32'(db_jogada), 0);
    chk("rst.db_memoria", 32'(db_memoria), 0);
    chk("rst.eq_limite", 32'(enderecoIgualLimite), 1);
    chk("rst.fimC", 32'(fimC), 0);
    chk("rst.fimL", 32'(fimL), 0);
    chk("rst.timeout", 32'(timeout), 0);
    chk("rst.igual", 32'(igual), 1);
    chaves = 0;
    do_reset();

    // first read and compare
    step();
    chk("rd0.db_memoria", 32'(db_memoria), 32'h1);
    chaves = 4'b0001; registraR = 1; step(); registraR = 0;
    chk("cmp.igual_hit", 32'(igual), 1);
    chaves = 4'b0100; registraR = 1; step(); registraR = 0; chaves = 0;
    chk("cmp.igual_miss", 32'(igual), 0);
    chk("cmp.db_jogada", 32'(db_jogada), 32'h4);
    zeraR = 1; registraR = 1; chaves = 4'b0010; step(); idle(); chaves = 0;
    chk("zeraR_wins", 32'(db_jogada), 0);

    // counter wrap
    do_reset();
    contaC = 1;
    repeat (15) step();
    chk("wrap.cont15", 32'(db_contagem), 15);
    chk("wrap.fimC1", 32'(fimC), 1);
    step();
    chk("wrap.cont0", 32'(db_contagem), 0);
    chk("wrap.fimC0", 32'(fimC), 0);
    contaC = 0; contaL = 1;
    repeat (15) step();
    chk("wrap.fimL1", 32'(fimL), 1);
    step();
    chk("wrap.lim0", 32'(db_limite), 0);
    contaL = 0;

    // vector table: address/limit counters and their comparison
    do_reset();
    for (int i = 0; i < 9; i++) begin
      zeraC = tbl[i].zc; contaC = tbl[i].cc; zeraL = tbl[i].zl; contaL = tbl[i].cl;
      step();
      chk($sformatf("tbl%0d.cont", i), 32'(db_contagem), tbl[i].e_cont);
      chk($sformatf("tbl%0d.lim", i), 32'(db_limite), tbl[i].e_lim);
      chk($sformatf("tbl%0d.eq", i), 32'(enderecoIgualLimite), 32'(tbl[i].e_eq));
    end
    idle();

    // memory read-first and write-with-increment
    do_reset();
    contaC = 1; repeat (3) step(); contaC = 0;
    chaves = 4'b1000; registraR = 1; step(); registraR = 0; chaves = 0;
    gravaM = 1; step(); gravaM = 0;
    chk("mem.rf_old1", 32'(db_memoria), 32'h8);
    chaves = 4'b0010; registraR = 1; step(); registraR = 0; chaves = 0;
    gravaM = 1; step(); gravaM = 0;
    chk("mem.rf_old2", 32'(db_memoria), 32'h8);
    step();
    chk("mem.new", 32'(db_memoria), 32'h2);
    chaves = 4'b0100; registraR = 1; step(); registraR = 0; chaves = 0;
    gravaM = 1; contaC = 1; step(); idle();
    chk("mem.inc_addr", 32'(db_contagem), 4);
    step();
    chk("mem.word4", 32'(db_memoria), 32'h1);
    do_reset();
    contaC = 1; repeat (3) step(); contaC = 0;
    step();
    chk("mem.survives_reset", 32'(db_memoria), 32'h4);

    // play edge detector
    do_reset();
    chaves = 4'b0010; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      #1 pulses += int'(jogada_feita);
      step();
    end
    chk("edge.pulse1", pulses, 1);
    chaves = 0; step();
    chaves = 4'b0001; pulses = 0;
    for (int i = 0; i < 5; i++) begin
      #1 pulses += int'(jogada_feita);
      step();
    end
    chk("edge.pulse2", pulses, 1);
    chaves = 0;

    // timeout
    do_reset();
    contaT = 1;
    repeat (6) step();
    chk("to.before", 32'(timeout), 0);
    step();
`ifdef FLUXO_DADOS_TIMEOUT_EN
    chk("to.reached", 32'(timeout), 1);
    repeat (3) step();
    chk("to.held", 32'(timeout), 1);
    zeraT = 1; step(); zeraT = 0;
    chk("to.cleared", 32'(timeout), 0);
`else
    chk("to.off", 32'(timeout), 0);
    repeat (3) step();
    chk("to.off_held", 32'(timeout), 0);
`endif
    idle();

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset     = ($urandom_range(0, 19) == 0);
      zeraC     = ($urandom_range(0, 9) == 0);
      contaC    = ($urandom_range(0, 1) == 0);
      zeraL     = ($urandom_range(0, 11) == 0);
      contaL    = ($urandom_range(0, 3) == 0);
      zeraR     = ($urandom_range(0, 9) == 0);
      registraR = ($urandom_range(0, 2) == 0);
      gravaM    = ($urandom_range(0, 2) == 0);
      zeraT     = ($urandom_range(0, 14) == 0);
      contaT    = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 2) == 0) chaves = W'($urandom_range(0, 15));
      step();
    end
    reset = 0; idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
